// File: rtl/apb_req_arbiter.sv
// ============================================================================
// Module   : apb_req_arbiter
// Brief    : Two-requester round-robin front end feeding an APB master command
//            port; issues one transfer at a time and returns ack/read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_BIT = 12
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              m_valid,
    output logic              m_pwrite,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [DATA_W-1:0] m_pwdata,
    output logic [1:0]        m_pselx,
    input  logic              penable,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic              busy_q, busy_d;
    logic              m_valid_q, m_valid_d;
    logic              m_pwrite_q, m_pwrite_d;
    logic [ADDR_W-1:0] m_paddr_q, m_paddr_d;
    logic [DATA_W-1:0] m_pwdata_q, m_pwdata_d;
    logic [1:0]        m_pselx_q, m_pselx_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              w_sel;
    logic [ADDR_W-1:0] w_addr;

    // On a tie the requester that did not win last time gets the bus.
    assign w_sel  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign w_addr = w_sel ? req1_addr : req0_addr;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        m_valid_d    = 1'b0;
        m_pwrite_d   = m_pwrite_q;
        m_paddr_d    = m_paddr_q;
        m_pwdata_d   = m_pwdata_q;
        m_pselx_d    = m_pselx_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_id_d   = w_sel;
                    last_grant_d = w_sel;
                    m_valid_d    = 1'b1;
                    m_pwrite_d   = w_sel ? req1_write : req0_write;
                    m_paddr_d    = w_addr;
                    m_pwdata_d   = w_sel ? req1_wdata : req0_wdata;
                    m_pselx_d    = w_addr[SEL_BIT] ? 2'b10 : 2'b01;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (penable && pready) begin
                    if (grant_id_q) begin
                        rdata1_d = prdata;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = prdata;
                        ack0_d   = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                m_pselx_d  = 2'b00;
                m_pwrite_d = 1'b0;
                m_paddr_d  = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            busy_q       <= 1'b0;
            m_valid_q    <= 1'b0;
            m_pwrite_q   <= 1'b0;
            m_paddr_q    <= '0;
            m_pwdata_q   <= '0;
            m_pselx_q    <= 2'b00;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            m_valid_q    <= m_valid_d;
            m_pwrite_q   <= m_pwrite_d;
            m_paddr_q    <= m_paddr_d;
            m_pwdata_q   <= m_pwdata_d;
            m_pselx_q    <= m_pselx_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign req0_ack   = ack0_q;
    assign req0_rdata = rdata0_q;
    assign req1_ack   = ack1_q;
    assign req1_rdata = rdata1_q;
    assign m_valid    = m_valid_q;
    assign m_pwrite   = m_pwrite_q;
    assign m_paddr    = m_paddr_q;
    assign m_pwdata   = m_pwdata_q;
    assign m_pselx    = m_pselx_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ============================================================================
// Module   : tb_apb_req_arbiter
// Brief    : Directed self-checking bench for apb_req_arbiter; the bench plays
//            both requesters and the master/slave handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_req_arbiter;

    logic        pclk = 1'b0;
    logic        prst;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_ack, req1_ack;
    logic [31:0] req0_rdata, req1_rdata;
    logic        m_valid, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;
    logic [1:0]  m_pselx;
    logic        penable, pready;
    logic [31:0] prdata;
    logic        busy, grant_id;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_rd0, exp_rd1;

    apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_BIT(12)) dut (
        .pclk(pclk), .prst(prst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
        .m_valid(m_valid), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
        .m_pwdata(m_pwdata), .m_pselx(m_pselx),
        .penable(penable), .pready(pready), .prdata(prdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Precondition: requests driven, DUT in IDLE. Returns in the RESP cycle.
    // Master timing: setup cycle (penable=0) after the issue cycle, then access.
    task automatic run_xfer(input logic id, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wd, input int wait_n, input logic [31:0] rd);
        logic [1:0] sel;
        sel = addr[12] ? 2'b10 : 2'b01;
        tick();
        chk("issue_valid",  m_valid,  1);
        chk("issue_grant",  grant_id, id);
        chk("issue_busy",   busy,     1);
        chk("issue_paddr",  m_paddr,  addr);
        chk("issue_pwrite", m_pwrite, wr);
        chk("issue_pwdata", m_pwdata, wd);
        chk("issue_pselx",  m_pselx,  sel);
        penable = 1'b0;
        pready  = 1'b1;
        tick();
        chk("wait_valid_low", m_valid, 0);
        tick();
        chk("no_cmpl_wo_penable", {req1_ack, req0_ack}, 0);
        chk("wait_busy", busy, 1);
        penable = 1'b1;
        for (int i = 0; i < wait_n; i++) begin
            pready = 1'b0;
            tick();
            chk("wait_no_ack", {req1_ack, req0_ack}, 0);
            chk("wait_paddr",  m_paddr,  addr);
            chk("wait_pselx",  m_pselx,  sel);
            chk("wait_pwrite", m_pwrite, wr);
            chk("wait_pwdata", m_pwdata, wd);
            chk("wait_mvalid", m_valid,  0);
        end
        pready = 1'b1;
        prdata = rd;
        tick();
        if (id) exp_rd1 = rd;
        else    exp_rd0 = rd;
        chk("resp_ack0",   req0_ack,   !id);
        chk("resp_ack1",   req1_ack,   id);
        chk("resp_rdata0", req0_rdata, exp_rd0);
        chk("resp_rdata1", req1_rdata, exp_rd1);
        penable = 1'b0;
        pready  = 1'b0;
        prdata  = 32'h0;
    endtask

    task automatic post_resp();
        tick();
        chk("post_ack",    {req1_ack, req0_ack}, 0);
        chk("post_busy",   busy,     0);
        chk("post_pselx",  m_pselx,  0);
        chk("post_paddr",  m_paddr,  0);
        chk("post_pwrite", m_pwrite, 0);
    endtask

    task automatic do_reset();
        prst = 1'b1;
        tick();
        tick();
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        prst = 1'b0;
    endtask

    initial begin
        prst = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
        penable = 0; pready = 0; prdata = 0;

        do_reset();
        chk("rst_mvalid", m_valid,  0);
        chk("rst_busy",   busy,     0);
        chk("rst_grant",  grant_id, 0);
        chk("rst_pselx",  m_pselx,  0);
        chk("rst_paddr",  m_paddr,  0);
        chk("rst_acks",   {req1_ack, req0_ack}, 0);
        chk("rst_rdata0", req0_rdata, 0);
        chk("rst_rdata1", req1_rdata, 0);

        // Single write from requester 0, zero wait states.
        req0_valid = 1; req0_write = 1; req0_addr = 32'h0000_0010; req0_wdata = 32'hDEAD_BEEF;
        run_xfer(1'b0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 32'hAAAA_0001);
        req0_valid = 0;
        post_resp();

        // Read from requester 1 with five wait states, slave 2 decode.
        req1_valid = 1; req1_write = 0; req1_addr = 32'h0000_1004; req1_wdata = 32'h0000_0055;
        run_xfer(1'b1, 32'h0000_1004, 1'b0, 32'h0000_0055, 5, 32'h1234_5678);
        req1_valid = 0;
        post_resp();

        // Both continuously valid from reset: grants alternate starting with 0.
        do_reset();
        req0_valid = 1; req0_write = 1; req0_addr = 32'h0000_0020; req0_wdata = 32'h1111_1111;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h0000_1030; req1_wdata = 32'h2222_2222;
        run_xfer(1'b0, 32'h0000_0020, 1'b1, 32'h1111_1111, 0, 32'hC000_0000);
        post_resp();
        run_xfer(1'b1, 32'h0000_1030, 1'b0, 32'h2222_2222, 1, 32'hC000_0001);
        post_resp();
        run_xfer(1'b0, 32'h0000_0020, 1'b1, 32'h1111_1111, 0, 32'hC000_0002);
        post_resp();
        run_xfer(1'b1, 32'h0000_1030, 1'b0, 32'h2222_2222, 2, 32'hC000_0003);
        req0_valid = 0;
        req1_valid = 0;
        post_resp();

        // Slave strobes while idle with nothing pending must be ignored.
        penable = 1; pready = 1; prdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_spurious_busy",   busy,    0);
            chk("idle_spurious_mvalid", m_valid, 0);
            chk("idle_spurious_ack",    {req1_ack, req0_ack}, 0);
        end
        penable = 0; pready = 0; prdata = 0;

        // Reset while waiting on the slave; requester 0 last won beforehand.
        req0_valid = 1; req0_write = 1; req0_addr = 32'h0000_0040; req0_wdata = 32'h4444_4444;
        tick();
        chk("pre_rst_grant", grant_id, 0);
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        prst = 1'b1;
        tick();
        chk("mid_rst_busy",   busy,     0);
        chk("mid_rst_mvalid", m_valid,  0);
        chk("mid_rst_pselx",  m_pselx,  0);
        chk("mid_rst_paddr",  m_paddr,  0);
        chk("mid_rst_pwrite", m_pwrite, 0);
        chk("mid_rst_pwdata", m_pwdata, 0);
        chk("mid_rst_ack",    {req1_ack, req0_ack}, 0);
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        prst = 1'b0;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h0000_1050; req1_wdata = 32'h0;
        run_xfer(1'b0, 32'h0000_0040, 1'b1, 32'h4444_4444, 0, 32'h0BAD_F00D);
        req0_valid = 0;
        req1_valid = 0;
        post_resp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Two-requester round-robin front end that sequences APB transfers into the apb_master command interface. It accepts one request at a time from requester 0 or 1 and drives it into the master as a one-cycle valid pulse. It then holds the command fields stable until the slave completes, and returns read data with a one-cycle ack to the winning requester. It also decodes the slave select from the request address.

Parameters:
ADDR_W, 32, request/APB address width
DATA_W, 32, request/APB data width
SEL_BIT, 12, address bit that selects the slave: 0 selects pselx 2'b01, 1 selects 2'b10

Ports:
pclk  in  1  clock; all logic on the rising edge
prst  in  1  reset, synchronous, active-high
req0_valid  in  1  requester 0 has a pending transfer
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  requester 0 address
req0_wdata  in  DATA_W  requester 0 write data
req0_ack  out  1  one-cycle completion strobe to requester 0
req0_rdata  out  DATA_W  read data, valid while req0_ack=1
req1_valid, req1_write, req1_addr, req1_wdata, req1_ack, req1_rdata: same as requester 0, for requester 1
m_valid  out  1  start pulse to the master's valid input
m_pwrite  out  1  to master pwrite_m
m_paddr  out  ADDR_W  to master paddr_m
m_pwdata  out  DATA_W  to master pwdata_m
m_pselx  out  2  to master pselx_m
penable  in  1  master penable
pready  in  1  slave pready
prdata  in  DATA_W  slave read data
busy  out  1  high in every state except IDLE
grant_id  out  1  requester currently or last granted

Behaviour:
- Reset (prst=1 at an edge) forces state IDLE and clears all outputs and holding registers to 0. last_grant is set to 1, so requester 0 wins the first contest. Reset mid-transfer abandons the transfer with no ack; system-level reset of the master is assumed concurrent.
- All outputs are registered.
- States:
  - IDLE: if exactly one reqN_valid is high, grant it. If both are high, grant the requester != last_grant. On grant, latch write/addr/wdata into m_pwrite/m_paddr/m_pwdata, set grant_id and last_grant, and go to ISSUE. If neither is high, stay.
  - m_pselx decode at grant: addr[SEL_BIT]==0 gives 2'b01, otherwise 2'b10.
  - ISSUE: m_valid=1 for exactly this one cycle; next state WAIT.
  - WAIT: m_valid=0 and command fields held stable. When penable=1 and pready=1 at an edge, capture prdata into reqN_rdata (granted requester only) and go to RESP. Otherwise stay; there is no timeout.
  - RESP: reqN_ack=1 for the granted requester only, for this one cycle; reqN_rdata is valid. Next state IDLE.
- After RESP, m_pselx, m_pwrite and m_paddr clear to 0.
- Non-granted requester: its ack stays 0 and its rdata is unchanged.
- Requester rules: hold valid and fields stable until ack. Valid must be low in the cycle after ack unless a new request is intended.
- rdata is captured on writes too (don't-care); reqN_rdata holds until the next capture for that requester.
- Latency: request seen in IDLE at edge E gives m_valid high in cycle E+1. Ack follows 1 cycle after the completing edge. Minimum request-to-ack is 4 cycles with immediate pready.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1. A returning requester never waits more than one transfer.
- Requests that arrive while not in IDLE are not sampled until IDLE.
- pready while not in WAIT is ignored.

Test Plan:
- Reset, then req0 write addr 0x0000_0010 wdata 0xDEAD_BEEF with pready tied 1 → m_valid pulses 1 cycle, m_pselx=01, m_pwrite=1. req0_ack pulses once, 4 cycles after req0_valid was sampled; req1_ack stays 0.
- req1 read addr 0x0000_1004; slave holds pready=0 for 5 cycles, then 1 with prdata 0x1234_5678 → command fields stable throughout WAIT, m_pselx=10, req1_rdata=0x1234_5678 while req1_ack=1.
- Both requesters valid continuously for 4 transfers right after reset → grant_id sequence 0,1,0,1; exactly one ack per transfer.
- pready=1 while penable=0 during WAIT → no completion. Completion occurs only on the cycle where both penable and pready are 1.
- prst asserted in WAIT → next cycle state IDLE, busy=0, all m_* = 0, no ack. The first contest after reset is won by req0.
- Spurious pready pulses while IDLE with no request → no state change, m_valid stays 0.
